// File: rtl/sc_levelcounter_param_if.sv
// Game-control to level-counter bus: state and crossing strobe in; level, level-up pulse and final-level flag out.
// Pure signal bundle with no flow control, so no latency and no backpressure.
interface sc_levelcounter_param_if #(
    parameter int CURRENTSTATE_DATAWIDTH = 2,
    parameter int LEVELCOUNTER_DATAWIDTH = 3
);
    logic [CURRENTSTATE_DATAWIDTH-1:0] CurrentState_InBus;
    logic                              CountSignal_InLow;
    logic [LEVELCOUNTER_DATAWIDTH-1:0] Data_OutBus;
    logic                              LevelUp_OutHigh;
    logic                              MaxReached_OutHigh;

    modport master (
        output CurrentState_InBus,
        output CountSignal_InLow,
        input  Data_OutBus,
        input  LevelUp_OutHigh,
        input  MaxReached_OutHigh
    );

    modport slave (
        input  CurrentState_InBus,
        input  CountSignal_InLow,
        output Data_OutBus,
        output LevelUp_OutHigh,
        output MaxReached_OutHigh
    );
endinterface

// File: rtl/sc_levelcounter_param.sv
// Frogger level counter: one level per falling edge of the active-low strobe while in play; saturate or wrap at LEVEL_MAX.
// Outputs update on the same edge that samples the strobe fall; no backpressure, strobe events outside play are dropped.
module sc_levelcounter_param #(
    parameter int CURRENTSTATE_DATAWIDTH = 2,
    parameter int LEVELCOUNTER_DATAWIDTH = 3,
    parameter int LEVEL_START            = 0,
    parameter int LEVEL_MAX              = 7,
    parameter int ENDGAME_VALUE          = 4,
    parameter int WRAP_MODE              = 0
) (
    input  logic                   SC_LEVELCOUNTERP_CLOCK_50,
    input  logic                   SC_LEVELCOUNTERP_RESET_InHigh,
    sc_levelcounter_param_if.slave SC_LEVELCOUNTERP_Bus
);
    localparam int SW = CURRENTSTATE_DATAWIDTH;
    localparam int DW = LEVELCOUNTER_DATAWIDTH;

    localparam logic [SW-1:0] ST_AWAIT = SW'(0);
    localparam logic [SW-1:0] ST_PLAY  = SW'(1);
    localparam logic [SW-1:0] ST_END   = SW'(2);

    localparam logic [DW-1:0] LP_START   = DW'(LEVEL_START);
    localparam logic [DW-1:0] LP_MAX     = DW'(LEVEL_MAX);
    localparam logic [DW-1:0] LP_ENDGAME = DW'(ENDGAME_VALUE);
    localparam logic [DW-1:0] LP_ONE     = DW'(1);

    logic [SW-1:0] w_state;
    logic          w_strobe;
    logic          w_event;
    logic [DW-1:0] w_data_inc;
    logic [DW-1:0] w_data_nxt;
    logic          w_levelup_nxt;
    logic          w_max_nxt;

    logic          r_prev;
    logic [DW-1:0] r_data;
    logic          r_levelup;
    logic          r_max;

    assign w_state    = SC_LEVELCOUNTERP_Bus.CurrentState_InBus;
    assign w_strobe   = SC_LEVELCOUNTERP_Bus.CountSignal_InLow;
    assign w_event    = r_prev & ~w_strobe;
    assign w_data_inc = r_data + LP_ONE;

    always_comb begin
        w_data_nxt    = r_data;
        w_levelup_nxt = 1'b0;
        w_max_nxt     = r_max;
        case (w_state)
            ST_AWAIT: begin
                w_data_nxt = LP_START;
                w_max_nxt  = 1'b0;
            end
            ST_PLAY: begin
                if (w_event) begin
                    if (r_data < LP_MAX) begin
                        w_data_nxt    = w_data_inc;
                        w_levelup_nxt = 1'b1;
                        w_max_nxt     = (w_data_inc == LP_MAX);
                    end else if (WRAP_MODE != 0) begin
                        w_data_nxt    = LP_START;
                        w_levelup_nxt = 1'b1;
                        w_max_nxt     = 1'b0;
                    end
                end
            end
            ST_END: begin
                w_data_nxt = LP_ENDGAME;
            end
            default: begin
            end
        endcase
    end

    // Prev follows the strobe even in reset, so a strobe held low across release is already "seen".
    always_ff @(posedge SC_LEVELCOUNTERP_CLOCK_50) begin
        r_prev <= w_strobe;
        if (SC_LEVELCOUNTERP_RESET_InHigh) begin
            r_data    <= LP_START;
            r_levelup <= 1'b0;
            r_max     <= 1'b0;
        end else begin
            r_data    <= w_data_nxt;
            r_levelup <= w_levelup_nxt;
            r_max     <= w_max_nxt;
        end
    end

    assign SC_LEVELCOUNTERP_Bus.Data_OutBus        = r_data;
    assign SC_LEVELCOUNTERP_Bus.LevelUp_OutHigh    = r_levelup;
    assign SC_LEVELCOUNTERP_Bus.MaxReached_OutHigh = r_max;
endmodule

// File: tb/tb_sc_levelcounter_param.sv
// Directed bench for the level counter: one saturating and one wrapping instance driven in lockstep.
module tb_sc_levelcounter_param;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    sc_levelcounter_param_if #(.CURRENTSTATE_DATAWIDTH(2), .LEVELCOUNTER_DATAWIDTH(3)) bs ();
    sc_levelcounter_param_if #(.CURRENTSTATE_DATAWIDTH(2), .LEVELCOUNTER_DATAWIDTH(3)) bw ();

    sc_levelcounter_param #(.WRAP_MODE(0)) u_sat (
        .SC_LEVELCOUNTERP_CLOCK_50    (clk),
        .SC_LEVELCOUNTERP_RESET_InHigh(rst),
        .SC_LEVELCOUNTERP_Bus         (bs)
    );

    sc_levelcounter_param #(.WRAP_MODE(1)) u_wrap (
        .SC_LEVELCOUNTERP_CLOCK_50    (clk),
        .SC_LEVELCOUNTERP_RESET_InHigh(rst),
        .SC_LEVELCOUNTERP_Bus         (bw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic [1:0] st, input logic strobe);
        bs.CurrentState_InBus = st;
        bw.CurrentState_InBus = st;
        bs.CountSignal_InLow  = strobe;
        bw.CountSignal_InLow  = strobe;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int es;
        int ew;
        errors = 0;
        checks = 0;

        // Reset, then await with strobe toggling
        rst = 1'b1;
        drv(2'd0, 1'b1);
        step();
        step();
        chk("rst_data", bs.Data_OutBus, 0);
        chk("rst_lu", bs.LevelUp_OutHigh, 0);
        chk("rst_max", bs.MaxReached_OutHigh, 0);
        chk("rst_data_w", bw.Data_OutBus, 0);
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            drv(2'd0, 1'b0);
            step();
            chk("await_lu", bs.LevelUp_OutHigh, 0);
            chk("await_data", bs.Data_OutBus, 0);
            drv(2'd0, 1'b1);
            step();
            chk("await_max", bs.MaxReached_OutHigh, 0);
        end

        // Play with a strobe held low for 5 cycles, three times
        drv(2'd1, 1'b1);
        step();
        chk("play_entry", bs.Data_OutBus, 0);
        for (int n = 1; n <= 3; n++) begin
            drv(2'd1, 1'b0);
            step();
            chk("play_data", bs.Data_OutBus, n);
            chk("play_lu", bs.LevelUp_OutHigh, 1);
            for (int j = 0; j < 4; j++) begin
                step();
                chk("play_hold_lu", bs.LevelUp_OutHigh, 0);
                chk("play_hold_data", bs.Data_OutBus, n);
            end
            drv(2'd1, 1'b1);
            step();
            chk("play_release", bs.Data_OutBus, n);
        end

        // Strobe falls during pause: no increment on resume
        drv(2'd3, 1'b0);
        step();
        chk("pause_data", bs.Data_OutBus, 3);
        chk("pause_lu", bs.LevelUp_OutHigh, 0);
        drv(2'd1, 1'b0);
        step();
        chk("resume_data", bs.Data_OutBus, 3);
        chk("resume_lu", bs.LevelUp_OutHigh, 0);
        step();
        chk("resume_data2", bs.Data_OutBus, 3);

        // End-game forces the fixed code
        drv(2'd2, 1'b0);
        step();
        chk("end_data", bs.Data_OutBus, 4);
        chk("end_lu", bs.LevelUp_OutHigh, 0);
        chk("end_max", bs.MaxReached_OutHigh, 0);
        chk("end_data_w", bw.Data_OutBus, 4);

        // Back to await, then nine strobes: saturate vs wrap
        drv(2'd0, 1'b1);
        step();
        chk("await2_data", bs.Data_OutBus, 0);
        drv(2'd1, 1'b1);
        step();
        for (int i = 1; i <= 9; i++) begin
            es = (i < 7) ? i : 7;
            ew = (i <= 7) ? i : i - 8;
            drv(2'd1, 1'b0);
            step();
            chk("sat_data", bs.Data_OutBus, es);
            chk("sat_lu", bs.LevelUp_OutHigh, (i <= 7) ? 1 : 0);
            chk("sat_max", bs.MaxReached_OutHigh, (i >= 7) ? 1 : 0);
            chk("wrap_data", bw.Data_OutBus, ew);
            chk("wrap_lu", bw.LevelUp_OutHigh, 1);
            chk("wrap_max", bw.MaxReached_OutHigh, (i == 7) ? 1 : 0);
            drv(2'd1, 1'b1);
            step();
            chk("sat_lu_off", bs.LevelUp_OutHigh, 0);
            chk("wrap_lu_off", bw.LevelUp_OutHigh, 0);
        end

        // End-game keeps the final-level flag
        drv(2'd2, 1'b1);
        step();
        chk("end2_data", bs.Data_OutBus, 4);
        chk("end2_max", bs.MaxReached_OutHigh, 1);
        chk("end2_max_w", bw.MaxReached_OutHigh, 0);

        // Mid-game reset at level 5 with the strobe held low
        drv(2'd0, 1'b1);
        step();
        drv(2'd1, 1'b1);
        step();
        for (int i = 0; i < 4; i++) begin
            drv(2'd1, 1'b0);
            step();
            drv(2'd1, 1'b1);
            step();
        end
        chk("pre5_data", bs.Data_OutBus, 4);
        drv(2'd1, 1'b0);
        step();
        chk("at5_data", bs.Data_OutBus, 5);
        rst = 1'b1;
        step();
        chk("mrst_data", bs.Data_OutBus, 0);
        chk("mrst_max", bs.MaxReached_OutHigh, 0);
        chk("mrst_lu", bs.LevelUp_OutHigh, 0);
        rst = 1'b0;
        step();
        chk("post_rst_data", bs.Data_OutBus, 0);
        chk("post_rst_lu", bs.LevelUp_OutHigh, 0);
        step();
        chk("post_rst_data2", bs.Data_OutBus, 0);
        drv(2'd1, 1'b1);
        step();
        drv(2'd1, 1'b0);
        step();
        chk("post_rst_inc", bs.Data_OutBus, 1);
        chk("post_rst_inc_lu", bs.LevelUp_OutHigh, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
